bit4_parallel_adder: RTL and testbench
======================================

// Module: bit4_parallel_adder
// PURPOSE
//  4-bit ripple-carry parallel adder: sum/carry = a + b + cin, with registered outputs.
//  Leaf arithmetic block for small datapaths and the 100-day exercise suite.
//  Combinational ripple chain of full adders feeds one output register stage.
//  Free-running: no handshake; a new operand set is accepted every clock.
// PARAMETERS
//  WIDTH   4   operand/sum width; only 4 is verified, the RTL is generic in WIDTH>=1
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset; deassertion is synchronous to clk
//  a       in   WIDTH  addend, unsigned (also read as two's complement for ovf)
//  b       in   WIDTH  addend, unsigned (also read as two's complement for ovf)
//  cin     in   1      carry-in
//  sum     out  WIDTH  registered low WIDTH bits of a+b+cin
//  carry   out  1      registered carry-out (bit WIDTH of a+b+cin)
//  ovf     out  1      registered signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset: while rst_n=0, sum=0, carry=0 and ovf=0 immediately, independent of clk.
//  - Latency 1: values of a/b/cin sampled at rising edge N appear on sum/carry/ovf
//    after edge N; outputs hold until the next edge.
//  - Arithmetic: {carry,sum} = a + b + cin, full WIDTH+1-bit result, no saturation.
//    Extremes: 4'hF+4'hF+1 -> {1,4'hF}; 0+0+0 -> {0,4'h0}.
//  - Ripple: c[0]=cin; for bit i: s[i]=a[i]^b[i]^c[i],
//    c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])); carry=c[WIDTH].
//  - ovf = c[WIDTH]^c[WIDTH-1]; e.g. 4'h7+4'h1+0 -> ovf=1; 4'h8+4'h8+0 -> ovf=1.
//  - X/Z on inputs is not handled; the bench drives known values only.
//  - Reset asserted mid-stream: outputs clear at once. First edge after release
//    registers the inputs present at that edge; nothing is retained across reset.
// STRUCTURE
//  - Sub-module full_adder (a,b,cin -> s,cout), purely combinational.
//    Instantiated WIDTH times via generate, chained cout->cin.
//  - Top module contains the carry-vector wire and one always block that is
//    async-reset, registers sum, carry and ovf.
//  - Shared package holds the ADD_WIDTH=4 localparam and a reset-value constant
//    (all zeros). No typedefs are needed.
//  - Derive sum only from the gate-level chain; no behavioural '+'.
// TESTING
//  - Reset: hold rst_n=0 with a=4'h5,b=4'h3,cin=1 over clocks -> sum=0,carry=0,ovf=0.
//  - Basic: a=4'h3,b=4'h4,cin=0 -> next edge sum=4'h7,carry=0,ovf=0.
//  - Max carry: a=4'hF,b=4'hF,cin=1 -> sum=4'hF,carry=1; a=4'hF,b=4'h0,cin=1 -> sum=0,carry=1.
//  - Overflow: a=4'h7,b=4'h1,cin=0 -> sum=4'h8,carry=0,ovf=1;
//    a=4'h8,b=4'h8,cin=0 -> sum=0,carry=1,ovf=1.
//  - Async reset mid-run: drop rst_n between edges -> outputs 0 before the next edge;
//    release, apply a=2,b=2,cin=1 -> sum=4'h5 after the first edge.
//  - Random: 1000 cycles of $random a/b/cin; compare {carry,sum} with a+b+cin delayed
//    one cycle, and ovf with (a[3]==b[3])&&(sum[3]!=a[3]).

Source files
------------

// File: rtl/bit4_parallel_adder_pkg.sv
// ---------------------------------------------------------------------------
// bit4_parallel_adder_pkg
//   Constants shared by the ripple-carry adder slice.
//   ADD_WIDTH   : default operand/sum width of the adder.
//   ADD_RST_BIT : value every output flop takes while reset is asserted.
//                 Replicate it to the needed width, e.g. {W{ADD_RST_BIT}}.
// ---------------------------------------------------------------------------
package bit4_parallel_adder_pkg;

    localparam int   ADD_WIDTH   = 4;
    localparam logic ADD_RST_BIT = 1'b0;

endpackage : bit4_parallel_adder_pkg

// File: rtl/bit4_parallel_adder_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   One-bit combinational full adder. It is the cell of the ripple chain.
//   a, b : addend bits
//   cin  : carry in from the next-lower bit
//   s    : sum bit, a ^ b ^ cin
//   cout : carry out to the next-higher bit
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term. It is shared by the sum and carry equations.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/bit4_parallel_adder.sv
// ---------------------------------------------------------------------------
// bit4_parallel_adder
//   Ripple-carry adder with one output register stage: {carry,sum} = a+b+cin.
//   A new operand set is accepted on every clock and appears one edge later.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (release is synchronous to clk)
//   a, b  : WIDTH-bit addends (unsigned; two's complement for ovf)
//   cin   : carry in
//   sum   : registered low WIDTH bits of the result
//   carry : registered carry out of the MSB
//   ovf   : registered signed overflow (carry into MSB ^ carry out of MSB)
// ---------------------------------------------------------------------------
module bit4_parallel_adder
    import bit4_parallel_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    // c[i] is the carry into bit i. c[WIDTH] is the final carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s_w;

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             carry_d, carry_q;
    logic             ovf_d,   ovf_q;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (c[gi]),
                .s    (s_w[gi]),
                .cout (c[gi+1])
            );
        end
    endgenerate

    always_comb begin
        sum_d   = s_w;
        carry_d = c[WIDTH];
        // The carries into and out of the sign bit differ exactly when the
        // two's-complement result falls outside the representable range.
        ovf_d   = c[WIDTH] ^ c[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= {WIDTH{ADD_RST_BIT}};
            carry_q <= ADD_RST_BIT;
            ovf_q   <= ADD_RST_BIT;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule : bit4_parallel_adder

// File: tb/tb_bit4_parallel_adder.sv
// ---------------------------------------------------------------------------
// tb_bit4_parallel_adder
//   Testbench for bit4_parallel_adder. It uses a table of hand-computed
//   vectors, hand-written reset and hold sequences, and a randomised run
//   checked against a reference model.
// ---------------------------------------------------------------------------
module tb_bit4_parallel_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       carry;
    logic       ovf;

    int n_checks = 0;
    int n_passed = 0;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_sum;
        logic       exp_carry;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[8];

    bit4_parallel_adder #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .carry (carry),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {ovf,carry,sum} against the required value.
    task automatic check(input string name, input logic [5:0] got,
                         input logic [5:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got {ovf,carry,sum}=%b_%b_%h required %b_%b_%h",
                     name, got[5], got[4], got[3:0], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Drive the operands, take one rising edge, and sample 1 time unit later.
    task automatic apply(input logic [3:0] ta, input logic [3:0] tb,
                         input logic tc);
        a   = ta;
        b   = tb;
        cin = tc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] full;
        logic [3:0] ra, rb;
        logic       rc;
        logic       rovf;

        vecs[0] = '{"basic_3p4",   4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0};
        vecs[1] = '{"max_FpFp1",   4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[2] = '{"carry_Fp0p1", 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[3] = '{"ovf_7p1",     4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[4] = '{"ovf_8p8",     4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[5] = '{"zero",        4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[6] = '{"ovf_cin_7p0", 4'h7, 4'h0, 1'b1, 4'h8, 1'b0, 1'b1};
        vecs[7] = '{"neg_Ep3p1",   4'hE, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0};

        // Hold reset with non-zero operands across several clocks.
        rst_n = 1'b0;
        a     = 4'h5;
        b     = 4'h3;
        cin   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold_%0d", i), {ovf, carry, sum}, 6'b0);
        end
        $display("reset held 3 cycles: sum=%h carry=%b ovf=%b", sum, carry, ovf);

        // Release reset away from the rising edge.
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].cin);
            check(vecs[i].name, {ovf, carry, sum},
                  {vecs[i].exp_ovf, vecs[i].exp_carry, vecs[i].exp_sum});
            $display("vec %s: a=%h b=%h cin=%b -> sum=%h carry=%b ovf=%b",
                     vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin,
                     sum, carry, ovf);
        end

        // Outputs must hold until the next edge, even when the inputs change.
        apply(4'h9, 4'h9, 1'b1);          // 9+9+1 = 19 -> {1,3}, ovf=1
        a   = 4'h1;
        b   = 4'h1;
        cin = 1'b0;
        #3;
        check("hold_between_edges", {ovf, carry, sum}, {1'b1, 1'b1, 4'h3});
        $display("hold: sum=%h carry=%b ovf=%b", sum, carry, ovf);
        @(posedge clk);
        #1;
        check("after_hold_1p1", {ovf, carry, sum}, {1'b0, 1'b0, 4'h2});

        // Reset asserted mid-run: outputs clear before the next edge.
        apply(4'hF, 4'hF, 1'b1);
        check("pre_async_FpFp1", {ovf, carry, sum}, {1'b0, 1'b1, 4'hF});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", {ovf, carry, sum}, 6'b0);
        $display("async reset mid-run: sum=%h carry=%b ovf=%b", sum, carry, ovf);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'h2, 4'h2, 1'b1);
        check("post_reset_2p2p1", {ovf, carry, sum}, {1'b0, 1'b0, 4'h5});
        $display("post reset: a=2 b=2 cin=1 -> sum=%h carry=%b ovf=%b",
                 sum, carry, ovf);

        // Randomised run checked against a reference model.
        for (int i = 0; i < 1000; i++) begin
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
            rovf = (ra[3] == rb[3]) && (full[3] != ra[3]);
            apply(ra, rb, rc);
            check($sformatf("rand_%0d", i), {ovf, carry, sum}, {rovf, full});
        end
        $display("random run: 1000 vectors applied");

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule : tb_bit4_parallel_adder
